// File: rtl/mxint8_block_assembler_pkg.sv
// ---------------------------------------------------------------------------
// mxint8_block_assembler_pkg
//
// Shared MXINT8 format constants used by the ALU input stage and its bench.
//   MXINT8_ELEMENT_WIDTH : bits per two's-complement element
//   BLOCK_SIZE           : elements per MXINT8 block
//   MXINT8_SCALE_WIDTH   : bits of the shared E8M0 scale
//   MXINT8_UNUSED_ENCODE : the reserved element code (-128); consumers decide
//                          what it means, the assembler passes it through
//   cnt_width()          : beat counter width, never less than one bit
// ---------------------------------------------------------------------------
package mxint8_block_assembler_pkg;

   localparam int MXINT8_ELEMENT_WIDTH = 8;
   localparam int BLOCK_SIZE           = 32;
   localparam int MXINT8_SCALE_WIDTH   = 8;

   localparam logic [MXINT8_ELEMENT_WIDTH-1:0] MXINT8_UNUSED_ENCODE = 8'h80;

   // A single-beat block still needs a one-bit counter to keep the
   // declarations legal.
   function automatic int cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage : mxint8_block_assembler_pkg

// File: rtl/mxint8_block_assembler.sv
// ---------------------------------------------------------------------------
// mxint8_block_assembler
//
// Input stage of the MXINT8 ALU datapath. Collects BEATS narrow beats of
// LANES elements each into one full block (shared scale + BLOCK_SIZE
// elements) and presents it in parallel, held stable under valid/ready.
// A single output buffer is used; the beat that completes a handshake may
// simultaneously be beat 0 of the next block, so back-to-back blocks run at
// one block per BEATS cycles.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_in_valid          input beat valid
//   o_in_ready          input beat accepted when i_in_valid & o_in_ready
//   i_in_scale          shared scale, sampled on beat 0 only
//   i_in_elements       LANES packed elements, lane k = bits [8k+7:8k]
//   i_in_last           end-of-block marker (framing check only)
//   o_out_valid         assembled block valid
//   i_out_ready         downstream accepts block
//   o_scale             block scale
//   o_mxint8_elements   block elements; j from beat j/LANES, lane j%LANES
//   o_frame_err         1-cycle framing error pulse (framing check only)
//
// Build option:
//   MXINT8_ASM_FRAME_CHECK_EN  when defined, i_in_last is checked against
//                              the beat count and o_frame_err is present;
//                              otherwise framing is purely count-based.
// ---------------------------------------------------------------------------
module mxint8_block_assembler
   import mxint8_block_assembler_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic                                      i_clk,
   input  logic                                      i_rst_n,
   input  logic                                      i_in_valid,
   output logic                                      o_in_ready,
   input  logic [MXINT8_SCALE_WIDTH-1:0]             i_in_scale,
   input  logic [LANES*MXINT8_ELEMENT_WIDTH-1:0]     i_in_elements,
   input  logic                                      i_in_last,
   output logic                                      o_out_valid,
   input  logic                                      i_out_ready,
   output logic [MXINT8_SCALE_WIDTH-1:0]             o_scale,
   output logic [MXINT8_ELEMENT_WIDTH-1:0]           o_mxint8_elements [0:BLOCK_SIZE-1]
`ifdef MXINT8_ASM_FRAME_CHECK_EN
   ,
   output logic                                      o_frame_err
`endif
);

   localparam int EW    = MXINT8_ELEMENT_WIDTH;
   localparam int BEATS = BLOCK_SIZE / LANES;
   localparam int CNT_W = cnt_width(BEATS);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   localparam logic S_FILL = 1'b0;
   localparam logic S_FULL = 1'b1;

   logic             state_q,    state_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [MXINT8_SCALE_WIDTH-1:0] scale_q;
   logic [EW-1:0]    elem_q [0:BLOCK_SIZE-1];

   logic accept;
   logic handshake;
   logic last_beat;
   logic frame_abort;   // early i_in_last: drop the partial block

   // ------------------------------------------------------------------------
   // Framing decode
   // ------------------------------------------------------------------------
`ifdef MXINT8_ASM_FRAME_CHECK_EN
   logic frame_err_q, frame_err_d;

   assign frame_abort = accept & i_in_last & ~last_beat;
   // Flag both an early marker and a missing marker on the final beat.
   assign frame_err_d = accept & (i_in_last ^ last_beat);
   assign o_frame_err = frame_err_q;
`else
   logic unused_in_last;

   assign frame_abort    = 1'b0;
   assign unused_in_last = i_in_last;
`endif

   assign accept    = i_in_valid & o_in_ready;
   assign handshake = o_out_valid & i_out_ready;
   assign last_beat = (beat_cnt_q == LAST_BEAT);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge values regardless of process ordering.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_FILL;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   // NOTE: every output of a combinational block gets a default first so no
   // path through the case leaves it unassigned and infers a latch.
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;

      if (accept) begin
         beat_cnt_d = (last_beat | frame_abort) ? '0 : beat_cnt_q + 1'b1;
      end

      case (state_q)
         S_FILL: begin
            if (accept & last_beat) begin
               state_d = S_FULL;
            end
         end
         S_FULL: begin
            // A beat accepted here is beat 0 of the next block; it only
            // keeps the buffer full when a block is a single beat.
            if (handshake) begin
               state_d = (accept & last_beat) ? S_FULL : S_FILL;
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // i_out_ready -> o_in_ready is the only input-to-output combinational
   // path; it lets the handshake cycle also take the next block's beat 0.
   always_comb begin
      o_out_valid = (state_q == S_FULL);
      o_in_ready  = i_rst_n & ((state_q == S_FILL) | i_out_ready);
   end

   // ------------------------------------------------------------------------
   // Block buffer
   // ------------------------------------------------------------------------
   // NOTE: the element array is reset even though it is storage: it drives
   // the output ports directly and must read as zero after reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         scale_q <= '0;
         for (int j = 0; j < BLOCK_SIZE; j++) begin
            elem_q[j] <= '0;
         end
      end else if (accept) begin
         if (beat_cnt_q == '0) begin
            scale_q <= i_in_scale;
         end
         // Elements are stored unmodified, including the unused encode.
         for (int j = 0; j < BLOCK_SIZE; j++) begin
            if (beat_cnt_q == CNT_W'(j / LANES)) begin
               elem_q[j] <= i_in_elements[(j % LANES)*EW +: EW];
            end
         end
      end
   end

`ifdef MXINT8_ASM_FRAME_CHECK_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= frame_err_d;
      end
   end
`endif

   assign o_scale           = scale_q;
   assign o_mxint8_elements = elem_q;

endmodule : mxint8_block_assembler

// File: tb/tb_mxint8_block_assembler.sv
// ---------------------------------------------------------------------------
// tb_mxint8_block_assembler
//
// Bench for mxint8_block_assembler (LANES=4, 8 beats per block). A queue
// model collects accepted beats into whole blocks and predicts valid,
// ready, output data and (with MXINT8_ASM_FRAME_CHECK_EN) framing errors.
// ---------------------------------------------------------------------------
module tb_mxint8_block_assembler;
   import mxint8_block_assembler_pkg::*;

   localparam int LANES = 4;
   localparam int EW    = MXINT8_ELEMENT_WIDTH;
   localparam int SW    = MXINT8_SCALE_WIDTH;
   localparam int BEATS = BLOCK_SIZE / LANES;

   typedef struct packed {
      logic [SW-1:0]            scale;
      logic [BLOCK_SIZE*EW-1:0] el;
   } blk_t;

   logic                i_clk = 1'b0;
   logic                i_rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic                o_in_ready;
   logic [SW-1:0]       in_scale = '0;
   logic [LANES*EW-1:0] in_elems = '0;
   logic                in_last = 1'b0;
   logic                o_out_valid;
   logic                out_ready = 1'b0;
   logic [SW-1:0]       o_scale;
   logic [EW-1:0]       o_mxint8_elements [0:BLOCK_SIZE-1];
`ifdef MXINT8_ASM_FRAME_CHECK_EN
   logic                o_frame_err;
`endif

   mxint8_block_assembler #(.LANES(LANES)) dut (
      .i_clk             (i_clk),
      .i_rst_n           (i_rst_n),
      .i_in_valid        (in_valid),
      .o_in_ready        (o_in_ready),
      .i_in_scale        (in_scale),
      .i_in_elements     (in_elems),
      .i_in_last         (in_last),
      .o_out_valid       (o_out_valid),
      .i_out_ready       (out_ready),
      .o_scale           (o_scale),
      .o_mxint8_elements (o_mxint8_elements)
`ifdef MXINT8_ASM_FRAME_CHECK_EN
      ,
      .o_frame_err       (o_frame_err)
`endif
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   blk_t          exp_q[$];      // completed blocks awaiting handshake
   logic [EW-1:0] part_q[$];     // elements of the block being collected
   logic [SW-1:0] part_scale;
   logic          exp_ferr = 1'b0;
   logic          last_acc = 1'b0;
   int            cyc = 0;
   int            hs_cycles[$];

   function automatic void model_clear();
      exp_q.delete();
      part_q.delete();
      exp_ferr = 1'b0;
   endfunction

   function automatic void model_accept();
      blk_t blk;
      if (part_q.size() == 0) part_scale = in_scale;
      for (int k = 0; k < LANES; k++) part_q.push_back(in_elems[k*EW +: EW]);
`ifdef MXINT8_ASM_FRAME_CHECK_EN
      if (in_last && part_q.size() < BLOCK_SIZE) begin
         part_q.delete();
         exp_ferr = 1'b1;
      end else if (part_q.size() == BLOCK_SIZE && !in_last) begin
         exp_ferr = 1'b1;
      end
`endif
      if (part_q.size() == BLOCK_SIZE) begin
         blk.scale = part_scale;
         for (int j = 0; j < BLOCK_SIZE; j++) blk.el[j*EW +: EW] = part_q[j];
         exp_q.push_back(blk);
         part_q.delete();
      end
   endfunction

   // One clock cycle: entered and left at posedge+1. Compares the DUT
   // against the model mid-cycle, then advances the model across the edge.
   task automatic step();
      logic exp_valid, exp_ready, acc, hs;
      int   mism;
      #3;
      exp_valid = (exp_q.size() != 0);
      exp_ready = !exp_valid || out_ready;
      total++;
      if (o_out_valid !== exp_valid) begin
         bad++;
         $display("FAIL out_valid cyc=%0d: got %b want %b", cyc, o_out_valid, exp_valid);
      end
      total++;
      if (o_in_ready !== exp_ready) begin
         bad++;
         $display("FAIL in_ready cyc=%0d: got %b want %b", cyc, o_in_ready, exp_ready);
      end
      if (exp_valid) begin
         total++;
         if (o_scale !== exp_q[0].scale) begin
            bad++;
            $display("FAIL scale cyc=%0d: got %h want %h", cyc, o_scale, exp_q[0].scale);
         end
         mism = -1;
         for (int j = BLOCK_SIZE - 1; j >= 0; j--)
            if (o_mxint8_elements[j] !== exp_q[0].el[j*EW +: EW]) mism = j;
         total++;
         if (mism >= 0) begin
            bad++;
            $display("FAIL elements cyc=%0d: element[%0d] got %h want %h", cyc, mism,
                     o_mxint8_elements[mism], exp_q[0].el[mism*EW +: EW]);
         end
      end
`ifdef MXINT8_ASM_FRAME_CHECK_EN
      total++;
      if (o_frame_err !== exp_ferr) begin
         bad++;
         $display("FAIL frame_err cyc=%0d: got %b want %b", cyc, o_frame_err, exp_ferr);
      end
`endif
      acc      = in_valid && exp_ready;
      hs       = exp_valid && out_ready;
      last_acc = acc;
      @(posedge i_clk);
      #1;
      if (hs) begin
         void'(exp_q.pop_front());
         hs_cycles.push_back(cyc);
      end
      exp_ferr = 1'b0;
      if (acc) model_accept();
      cyc++;
   endtask

   // Offer one beat and hold it until accepted (bounded).
   task automatic send_beat(input logic [SW-1:0] scale, input logic [LANES*EW-1:0] elems,
                            input logic last);
      int waited = 0;
      in_valid = 1'b1;
      in_scale = scale;
      in_elems = elems;
      in_last  = last;
      step();
      while (!last_acc && waited < 64) begin
         step();
         waited++;
      end
      if (!last_acc) begin
         total++;
         bad++;
         $display("FAIL beat_accept: got not-accepted want accepted within 64 cycles");
      end
   endtask

   function automatic logic [LANES*EW-1:0] rand_beat();
      logic [LANES*EW-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*EW +: EW] = EW'($urandom);
      return v;
   endfunction

   task automatic send_rand_block(input logic [SW-1:0] scale);
      for (int b = 0; b < BEATS; b++)
         send_beat((b == 0) ? scale : SW'($urandom), rand_beat(), b == BEATS - 1);
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      int nz;
      i_rst_n = 1'b0;
      #3;
      nz = 0;
      for (int j = 0; j < BLOCK_SIZE; j++) if (o_mxint8_elements[j] !== '0) nz++;
      total++;
      if (o_out_valid !== 1'b0 || o_in_ready !== 1'b0 || o_scale !== '0 || nz != 0) begin
         bad++;
         $display("FAIL reset_state: got valid=%b ready=%b scale=%h nonzero=%0d want 0 0 00 0",
                  o_out_valid, o_in_ready, o_scale, nz);
      end
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      model_clear();
      step();
   endtask

   task automatic test_single_block();
      logic [LANES*EW-1:0] e;
      int nz;
      out_ready = 1'b1;
      for (int b = 0; b < BEATS; b++) begin
         for (int k = 0; k < LANES; k++) e[k*EW +: EW] = EW'(b*LANES + k);
         send_beat((b == 0) ? 8'h7F : SW'($urandom), e, b == BEATS - 1);
      end
      in_valid = 1'b0;
      #2;
      nz = 0;
      for (int j = 0; j < BLOCK_SIZE; j++) if (o_mxint8_elements[j] !== EW'(j)) nz++;
      total++;
      if (o_out_valid !== 1'b1 || o_scale !== 8'h7F || nz != 0) begin
         bad++;
         $display("FAIL single_block: got valid=%b scale=%h wrong=%0d want 1 7f 0",
                  o_out_valid, o_scale, nz);
      end
      #(-2 + 2);
      step();   // handshake
      step();   // valid must have dropped
   endtask

   task automatic test_stall();
      int accepted = 0;
      out_ready = 1'b0;
      send_rand_block(SW'($urandom));
      in_valid = 1'b1;
      in_scale = 8'h3C;
      in_elems = rand_beat();
      in_last  = 1'b0;
      repeat (5) begin
         step();
         if (last_acc) accepted++;
      end
      total++;
      if (accepted != 0) begin
         bad++;
         $display("FAIL stall_accept: got %0d beats accepted want 0", accepted);
      end
      out_ready = 1'b1;
      step();   // handshake plus beat 0 of the next block
      total++;
      if (!last_acc) begin
         bad++;
         $display("FAIL stall_release: got beat0 not accepted want accepted");
      end
      for (int b = 1; b < BEATS; b++) send_beat(SW'($urandom), rand_beat(), b == BEATS - 1);
      drain();
   endtask

   task automatic test_back_to_back();
      int first;
      out_ready = 1'b1;
      hs_cycles.delete();
      send_rand_block(8'h11);
      send_rand_block(8'h22);
      drain();
      total++;
      if (hs_cycles.size() != 2) begin
         bad++;
         $display("FAIL b2b_count: got %0d handshakes want 2", hs_cycles.size());
      end else begin
         first = hs_cycles[0];
         total++;
         if (hs_cycles[1] - first != BEATS) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d cycles want %0d", hs_cycles[1] - first, BEATS);
         end
      end
   endtask

   task automatic test_passthrough();
      out_ready = 1'b0;
      send_beat(8'h05, {8'h7F, 8'h01, 8'hFF, MXINT8_UNUSED_ENCODE}, 1'b0);
      for (int b = 1; b < BEATS; b++) send_beat(SW'($urandom), rand_beat(), b == BEATS - 1);
      in_valid = 1'b0;
      #2;
      total++;
      if (o_mxint8_elements[0] !== 8'h80 || o_mxint8_elements[1] !== 8'hFF ||
          o_mxint8_elements[2] !== 8'h01 || o_mxint8_elements[3] !== 8'h7F) begin
         bad++;
         $display("FAIL passthrough: got %h %h %h %h want 80 ff 01 7f",
                  o_mxint8_elements[0], o_mxint8_elements[1],
                  o_mxint8_elements[2], o_mxint8_elements[3]);
      end
      step();
      drain();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b1;
      for (int b = 0; b < 4; b++) send_beat(8'h44, rand_beat(), 1'b0);
      in_valid = 1'b0;
      #2;
      i_rst_n = 1'b0;
      #1;
      total++;
      if (o_out_valid !== 1'b0 || o_in_ready !== 1'b0 || o_scale !== '0 ||
          o_mxint8_elements[0] !== '0 || o_mxint8_elements[12] !== '0) begin
         bad++;
         $display("FAIL async_reset: got valid=%b ready=%b scale=%h e0=%h e12=%h want all 0",
                  o_out_valid, o_in_ready, o_scale, o_mxint8_elements[0], o_mxint8_elements[12]);
      end
      model_clear();
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      send_rand_block(8'h66);
      drain();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         in_scale  = SW'($urandom);
         in_elems  = rand_beat();
         in_last   = (part_q.size() == BLOCK_SIZE - LANES);
         step();
      end
      drain();
   endtask

`ifdef MXINT8_ASM_FRAME_CHECK_EN
   task automatic test_frame_check();
      out_ready = 1'b1;
      for (int b = 0; b < 3; b++) send_beat(8'h10, rand_beat(), b == 2);
      in_valid = 1'b0;
      step();   // frame_err pulse expected, no valid
      send_rand_block(8'h20);
      drain();
      for (int b = 0; b < BEATS; b++) send_beat(8'h30, rand_beat(), 1'b0);
      drain();
   endtask
`endif

   initial begin
      test_reset();
      test_single_block();
      test_stall();
      test_back_to_back();
      test_passthrough();
      test_async_reset();
      test_random();
`ifdef MXINT8_ASM_FRAME_CHECK_EN
      test_frame_check();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no completion want finish before 500000");
      $fatal(1);
   end

endmodule : tb_mxint8_block_assembler
